// File: rtl/gcd_run_ctrl_if.sv
// Register bus shared by the GCD run controller and the argument/result unpacker:
// 64-bit SRAM-style slave port with active-low chip enable, write enable and byte enables.
interface gcd_run_ctrl_if;
  logic        SRAM_CEn;
  logic [7:0]  SRAM_ADDR;
  logic [63:0] SRAM_WDATA;
  logic        SRAM_WEn;
  logic [7:0]  SRAM_WBEn;
  logic [63:0] SRAM_RDATA;

  modport master (
    output SRAM_CEn, SRAM_ADDR, SRAM_WDATA, SRAM_WEn, SRAM_WBEn,
    input  SRAM_RDATA
  );

  modport slave (
    input  SRAM_CEn, SRAM_ADDR, SRAM_WDATA, SRAM_WEn, SRAM_WBEn,
    output SRAM_RDATA
  );
endinterface

// File: rtl/gcd_run_ctrl.sv
// GCD run controller: start pulse, argument lock, cycle counting with timeout, soft-reset flush,
// status/IRQ. Define GCD_RUN_CTRL_DONE_SYNC_EN to pass DONE through a 2-flop synchronizer.
module gcd_run_ctrl #(
  parameter int          CNT_W           = 32,
  parameter logic [63:0] TIMEOUT_DEFAULT = 64'd1000000,
  parameter int          MASK_CYCLES     = 2,
  parameter int          SRST_CYCLES     = 4
) (
  input  logic         CLK,
  input  logic         RESETn,
  gcd_run_ctrl_if.slave bus,
  input  logic         DONE,
  output logic         GCD_START,
  output logic         GCD_SRSTn,
  output logic         ARG_LOCK,
  output logic         IRQ
);

  localparam int MSK_W  = (MASK_CYCLES < 1) ? 1 : $clog2(MASK_CYCLES + 1);
  localparam int SRST_W = (SRST_CYCLES < 2) ? 1 : $clog2(SRST_CYCLES + 1);
  localparam logic [MSK_W-1:0]  MASK_LOAD  = MSK_W'(MASK_CYCLES);
  localparam logic [SRST_W-1:0] FLUSH_LOAD = SRST_W'(SRST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TMO_RST    = CNT_W'(TIMEOUT_DEFAULT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_FLUSH  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [MSK_W-1:0]    mask_q, mask_d;
  logic [SRST_W-1:0]   flush_q, flush_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d;
  logic [CNT_W-1:0]    runs_q, runs_d;
  logic [CNT_W-1:0]    timeout_q, timeout_d;
  logic                done_f_q, done_f_d;
  logic                timeout_f_q, timeout_f_d;
  logic                abort_f_q, abort_f_d;
  logic                start_err_q, start_err_d;
  logic                irq_en_q, irq_en_d;
  logic [63:0]         rdata_q, rdata_d;
  logic                gcd_start_q, srstn_q, arg_lock_q, irq_q;

  logic                done_s;
  logic                bus_hit, bus_wr, bus_rd;
  logic                ctrl_wr, tmo_wr;
  logic                start_p, abort_p, clr_p;
  logic [2:0]          word;
  logic [63:0]         wbe_mask;
  logic [63:0]         rd_word;
  logic [CNT_W-1:0]    cyc_inc;
  logic                tmo_hit;
  logic                unused_bus;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

`ifdef GCD_RUN_CTRL_DONE_SYNC_EN
  logic [1:0] done_sync_q;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      done_sync_q <= 2'b00;
    end else begin
      done_sync_q <= {done_sync_q[0], DONE};
    end
  end

  assign done_s = done_sync_q[1];
`else
  assign done_s = DONE;
`endif

  // Bus decode: only the low 64-byte window hits; writes and pulses act at the sampling edge.
  assign word    = bus.SRAM_ADDR[5:3];
  assign bus_hit = !bus.SRAM_CEn && (bus.SRAM_ADDR[7:6] == 2'b00);
  assign bus_wr  = bus_hit && !bus.SRAM_WEn;
  assign bus_rd  = !bus.SRAM_CEn && bus.SRAM_WEn;
  assign ctrl_wr = bus_wr && (word == 3'd0) && !bus.SRAM_WBEn[0];
  assign tmo_wr  = bus_wr && (word == 3'd2);
  assign start_p = ctrl_wr && bus.SRAM_WDATA[0];
  assign abort_p = ctrl_wr && bus.SRAM_WDATA[1];
  assign clr_p   = ctrl_wr && bus.SRAM_WDATA[3];

  for (genvar i = 0; i < 8; i++) begin : g_wbe
    assign wbe_mask[i*8 +: 8] = {8{~bus.SRAM_WBEn[i]}};
  end

  assign unused_bus = ^{bus.SRAM_ADDR, bus.SRAM_WDATA, wbe_mask};

  assign cyc_inc = sat_inc(cycles_q);
  // A TIMEOUT lowered below the running count can no longer match, so saturation also ends the run.
  assign tmo_hit = (timeout_q != '0) && ((cyc_inc == timeout_q) || (&cyc_inc));

  always_comb begin
    rd_word = '0;
    case (word)
      3'd0:    rd_word[2]   = irq_en_q;
      3'd1:    rd_word[6:0] = {state_q, start_err_q, abort_f_q, timeout_f_q, done_f_q,
                               state_q != ST_IDLE};
      3'd2:    rd_word      = 64'(timeout_q);
      3'd3:    rd_word      = 64'(cycles_q);
      3'd4:    rd_word      = 64'(runs_q);
      default: rd_word      = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    flush_d     = flush_q;
    cycles_d    = cycles_q;
    runs_d      = runs_q;
    timeout_d   = timeout_q;
    done_f_d    = done_f_q;
    timeout_f_d = timeout_f_q;
    abort_f_d   = abort_f_q;
    start_err_d = start_err_q;
    irq_en_d    = irq_en_q;
    rdata_d     = rdata_q;

    if (bus_rd) begin
      rdata_d = bus_hit ? rd_word : '0;
    end

    if (ctrl_wr) begin
      irq_en_d = bus.SRAM_WDATA[2];
    end

    if (tmo_wr) begin
      timeout_d = (timeout_q & ~wbe_mask[CNT_W-1:0]) |
                  (bus.SRAM_WDATA[CNT_W-1:0] & wbe_mask[CNT_W-1:0]);
    end

    // CLR is applied first so that any flag raised in the same cycle survives.
    if (clr_p) begin
      done_f_d    = 1'b0;
      timeout_f_d = 1'b0;
      abort_f_d   = 1'b0;
      start_err_d = 1'b0;
    end

    if (start_p && (state_q != ST_IDLE)) begin
      start_err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_p) begin
          state_d     = ST_LAUNCH;
          done_f_d    = 1'b0;
          timeout_f_d = 1'b0;
          abort_f_d   = 1'b0;
          cycles_d    = '0;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_RUN;
        mask_d  = MASK_LOAD;
      end
      ST_RUN: begin
        cycles_d = cyc_inc;
        if (mask_q != '0) begin
          mask_d = mask_q - MSK_W'(1);
        end
        if (abort_p) begin
          state_d   = ST_FLUSH;
          abort_f_d = 1'b1;
          flush_d   = FLUSH_LOAD;
        end else if ((mask_q == '0) && done_s) begin
          state_d  = ST_IDLE;
          done_f_d = 1'b1;
          runs_d   = runs_q + CNT_W'(1);
        end else if (tmo_hit) begin
          state_d     = ST_FLUSH;
          timeout_f_d = 1'b1;
          flush_d     = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (flush_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          flush_d = flush_q - SRST_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      flush_q     <= '0;
      cycles_q    <= '0;
      runs_q      <= '0;
      timeout_q   <= TMO_RST;
      done_f_q    <= 1'b0;
      timeout_f_q <= 1'b0;
      abort_f_q   <= 1'b0;
      start_err_q <= 1'b0;
      irq_en_q    <= 1'b0;
      rdata_q     <= '0;
      gcd_start_q <= 1'b0;
      srstn_q     <= 1'b1;
      arg_lock_q  <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      flush_q     <= flush_d;
      cycles_q    <= cycles_d;
      runs_q      <= runs_d;
      timeout_q   <= timeout_d;
      done_f_q    <= done_f_d;
      timeout_f_q <= timeout_f_d;
      abort_f_q   <= abort_f_d;
      start_err_q <= start_err_d;
      irq_en_q    <= irq_en_d;
      rdata_q     <= rdata_d;
      // Core-facing outputs are decoded from next state so they line up with the state register.
      gcd_start_q <= (state_d == ST_LAUNCH);
      srstn_q     <= (state_d != ST_FLUSH);
      arg_lock_q  <= (state_d != ST_IDLE);
      irq_q       <= irq_en_d & (done_f_d | timeout_f_d | abort_f_d);
    end
  end

  assign bus.SRAM_RDATA = rdata_q;
  assign GCD_START      = gcd_start_q;
  assign GCD_SRSTn      = srstn_q;
  assign ARG_LOCK       = arg_lock_q;
  assign IRQ            = irq_q;

endmodule

// File: tb/tb_gcd_run_ctrl.sv
// Bench for gcd_run_ctrl: register reads are scored against a run-outcome model through a queue,
// core-side pins are checked directly while each run is driven.
module tb_gcd_run_ctrl;
  localparam int          MASK = 2;
  localparam int          SRST = 4;
  localparam logic [63:0] TDEF = 64'd1000000;
  localparam int          INF  = 1 << 30;
`ifdef GCD_RUN_CTRL_DONE_SYNC_EN
  localparam int DSYNC = 2;
`else
  localparam int DSYNC = 0;
`endif

  logic CLK    = 1'b0;
  logic RESETn = 1'b0;
  logic DONE   = 1'b0;
  logic GCD_START, GCD_SRSTn, ARG_LOCK, IRQ;

  gcd_run_ctrl_if bif ();

  gcd_run_ctrl #(
    .CNT_W(32), .TIMEOUT_DEFAULT(TDEF), .MASK_CYCLES(MASK), .SRST_CYCLES(SRST)
  ) dut (
    .CLK(CLK), .RESETn(RESETn), .bus(bif), .DONE(DONE),
    .GCD_START(GCD_START), .GCD_SRSTn(GCD_SRSTn), .ARG_LOCK(ARG_LOCK), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  string       name_q[$];

  // Reference model: register contents as the outcome of each whole run.
  bit          m_irq_en, m_dn, m_to, m_ab, m_err;
  logic [63:0] m_timeout, m_cycles, m_runs;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_irq_en = 0; m_dn = 0; m_to = 0; m_ab = 0; m_err = 0;
    m_timeout = TDEF; m_cycles = 0; m_runs = 0;
  endtask

  task automatic bus_idle();
    bif.SRAM_CEn   = 1'b1;
    bif.SRAM_WEn   = 1'b1;
    bif.SRAM_ADDR  = 8'h00;
    bif.SRAM_WDATA = 64'd0;
    bif.SRAM_WBEn  = 8'hFF;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [63:0] d, input logic [7:0] wben);
    bif.SRAM_CEn   = 1'b0;
    bif.SRAM_WEn   = 1'b0;
    bif.SRAM_ADDR  = a;
    bif.SRAM_WDATA = d;
    bif.SRAM_WBEn  = wben;
    @(negedge CLK);
    bus_idle();
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [63:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    bif.SRAM_CEn  = 1'b0;
    bif.SRAM_WEn  = 1'b1;
    bif.SRAM_ADDR = a;
    bif.SRAM_WBEn = 8'hFF;
    @(negedge CLK);
    bus_idle();
  endtask

  task automatic check_regs(input string tag);
    bus_read(8'h00, {61'd0, m_irq_en, 2'b00}, {tag, ".ctrl"});
    bus_read(8'h08, {57'd0, 2'd0, m_err, m_ab, m_to, m_dn, 1'b0}, {tag, ".status"});
    bus_read(8'h10, m_timeout, {tag, ".timeout"});
    bus_read(8'h18, m_cycles, {tag, ".cycles"});
    bus_read(8'h20, m_runs, {tag, ".runs"});
    check({tag, ".irq"}, 64'(IRQ), 64'(m_irq_en & (m_dn | m_to | m_ab)));
  endtask

  // k: RUN cycle where DONE rises (0 = never); t: TIMEOUT; a: ABORT cycle (0 = none);
  // s: busy-START cycle (0 = none, -1 = random within the run).
  task automatic run_one(input int k, input int t, input int a, input int s_in,
                         input bit irq, input bit stale, input bit clr, input string tag);
    int done_at, to_at, ab_at, fin, s, srst_exp, lock_cnt, srst_cnt, j;
    bit oc_dn, oc_to, oc_ab;
    done_at = stale ? MASK + 1 : ((k == 0) ? INF : ((k + DSYNC > MASK + 1) ? k + DSYNC : MASK + 1));
    to_at   = (t == 0) ? INF : t;
    ab_at   = (a == 0) ? INF : a;
    fin = ab_at; oc_ab = 1; oc_dn = 0; oc_to = 0;
    if (done_at < fin) begin fin = done_at; oc_ab = 0; oc_dn = 1; end
    if (to_at < fin) begin fin = to_at; oc_ab = 0; oc_dn = 0; oc_to = 1; end
    s = (s_in < 0) ? int'($urandom_range(fin, 1)) : s_in;

    DONE = stale;
    bus_write(8'h10, 64'(t), 8'h00);
    bus_write(8'h00, {60'd0, clr, irq, 2'b01}, 8'hFE);
    check({tag, ".start_hi"}, 64'(GCD_START), 64'd1);
    lock_cnt = 0; srst_cnt = 0; j = 0;
    while (ARG_LOCK === 1'b1 && j < 400) begin
      lock_cnt++;
      if (GCD_SRSTn === 1'b0) srst_cnt++;
      if (j == 1) check({tag, ".start_lo"}, 64'(GCD_START), 64'd0);
      if (j >= 1) begin
        DONE = stale || (k != 0 && j >= k);
        if (j <= fin && (j == a || j == s)) begin
          bif.SRAM_CEn   = 1'b0;
          bif.SRAM_WEn   = 1'b0;
          bif.SRAM_ADDR  = 8'h00;
          bif.SRAM_WBEn  = 8'hFE;
          bif.SRAM_WDATA = {60'd0, 1'b0, irq, (j == a), (j == s)};
        end else begin
          bus_idle();
        end
      end
      j++;
      @(negedge CLK);
    end
    bus_idle();
    DONE = 1'b0;
    check({tag, ".bounded"}, 64'(j < 400), 64'd1);

    if (clr) m_err = 0;
    m_irq_en  = irq;
    m_timeout = 64'(t);
    m_cycles  = 64'(fin);
    m_dn = oc_dn; m_to = oc_to; m_ab = oc_ab;
    m_runs = m_runs + 64'(oc_dn);
    if (s != 0) m_err = 1;
    srst_exp = oc_dn ? 0 : SRST;
    check({tag, ".lock_cycles"}, 64'(lock_cnt), 64'(1 + fin + srst_exp));
    check({tag, ".srst_cycles"}, 64'(srst_cnt), 64'(srst_exp));
    check_regs(tag);
  endtask

  // Scoreboard monitor: every read presented at an edge yields one RDATA to compare.
  initial begin
    logic [63:0] e;
    string       nm;
    forever begin
      @(posedge CLK);
      if (bif.SRAM_CEn === 1'b0 && bif.SRAM_WEn === 1'b1) begin
        #1;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rdata_unexpected: got 0x%0h expected no read data", bif.SRAM_RDATA);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check(nm, bif.SRAM_RDATA, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    model_reset();
    repeat (3) @(negedge CLK);
    check("reset.gcd_start", 64'(GCD_START), 64'd0);
    check("reset.gcd_srstn", 64'(GCD_SRSTn), 64'd1);
    check("reset.arg_lock",  64'(ARG_LOCK),  64'd0);
    check("reset.irq",       64'(IRQ),       64'd0);
    check("reset.rdata",     bif.SRAM_RDATA, 64'd0);
    RESETn = 1'b1;
    @(negedge CLK);
    check_regs("reset");

    run_one(10, 1000000, 0, 0, 1'b1, 1'b0, 1'b0, "normal");
    run_one(0, 0, 0, 0, 1'b1, 1'b1, 1'b0, "stale");
    run_one(0, 5, 0, 0, 1'b1, 1'b0, 1'b0, "timeout");
    run_one(4, 0, 4, 0, 1'b1, 1'b0, 1'b0, "abort_vs_done");
    run_one(6, 0, 0, 3, 1'b1, 1'b0, 1'b0, "start_busy");

    bus_write(8'h00, {60'd0, 1'b1, 1'b1, 2'b00}, 8'hFE);
    m_dn = 0; m_to = 0; m_ab = 0; m_err = 0;
    check("clr.irq_next", 64'(IRQ), 64'd0);
    check_regs("clr");

    bus_write(8'h10, 64'hFFFF_FFFF, 8'h00);
    bus_write(8'h10, 64'h1122_3344_AABB_CCDD, 8'b1111_1010);
    m_timeout = 64'hFFBB_FFDD;
    bus_read(8'h10, m_timeout, "timeout_bytes");

    for (int r = 0; r < 24; r++) begin
      int k, t, a, s;
      bit irq, clr, stale;
      k     = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(12, 1));
      t     = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(16, 1));
      a     = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(16, 1));
      stale = ($urandom_range(5, 0) == 0);
      if (k == 0 && t == 0 && a == 0 && !stale) t = int'($urandom_range(16, 1));
      s     = ($urandom_range(2, 0) == 0) ? -1 : 0;
      irq   = 1'($urandom_range(1, 0));
      clr   = ($urandom_range(3, 0) == 0);
      run_one(k, t, a, s, irq, stale, clr, "rnd");
    end

    bus_read(8'h20, m_runs, "pre_rst.runs");
    bus_write(8'h10, 64'h1234, 8'h00);
    bus_write(8'h00, 64'h5, 8'hFE);
    repeat (4) @(negedge CLK);
    check("rst.lock_before", 64'(ARG_LOCK), 64'd1);
    #2;
    RESETn = 1'b0;
    #1;
    check("rst.gcd_start", 64'(GCD_START), 64'd0);
    check("rst.gcd_srstn", 64'(GCD_SRSTn), 64'd1);
    check("rst.arg_lock",  64'(ARG_LOCK),  64'd0);
    check("rst.irq",       64'(IRQ),       64'd0);
    check("rst.rdata",     bif.SRAM_RDATA, 64'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    model_reset();
    @(negedge CLK);
    check_regs("after_rst");

    @(negedge CLK);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
